// File: rtl/cntr_pkg.sv
// Shared constants for the cascaded digit counter: default geometry and direction encoding.
package cntr_pkg;

    localparam int DEF_NUM_STAGES = 8;
    localparam int DEF_STAGE_W    = 4;
    localparam int DEF_MODULUS    = 16;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/cntr_stage.sv
// One modulo-MODULUS digit of the cascade: load with clamping, advance up or down, terminal flag.
module cntr_stage
    import cntr_pkg::*;
#(
    parameter int STAGE_W = DEF_STAGE_W,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               adv,
    input  logic               sense,
    input  logic               load,
    input  logic [STAGE_W-1:0] load_digit,
    output logic [STAGE_W-1:0] digit,
    output logic               tc
);

    localparam logic [STAGE_W-1:0] MAX_DIGIT = STAGE_W'(MODULUS - 1);
    localparam logic [STAGE_W:0]   MOD_EXT   = (STAGE_W + 1)'(MODULUS);

    logic [STAGE_W-1:0] digit_q;
    logic [STAGE_W-1:0] digit_d;
    logic [STAGE_W-1:0] load_clamped;

    // Widened compare so MODULUS == 2**STAGE_W never clamps.
    assign load_clamped = ({1'b0, load_digit} >= MOD_EXT) ? MAX_DIGIT : load_digit;
    assign tc           = (sense == DIR_UP) ? (digit_q == MAX_DIGIT) : (digit_q == '0);
    assign digit        = digit_q;

    // NOTE: digit_d is defaulted first so no path leaves it unassigned (no latch).
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_clamped;
        end else if (adv) begin
            if (sense == DIR_UP) begin
                digit_d = (digit_q == MAX_DIGIT) ? '0 : digit_q + 1'b1;
            end else begin
                digit_d = (digit_q == '0) ? MAX_DIGIT : digit_q - 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all stages update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/param_cascade_cntr.sv
// Parameterised cascaded up/down digit counter with parallel load and full roll-over pulse.
// Define CNTR_SATURATE_EN to hold at the end count instead of wrapping (adds the sat port).
module param_cascade_cntr
    import cntr_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int STAGE_W    = DEF_STAGE_W,
    parameter int MODULUS    = DEF_MODULUS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          sense,
    input  logic                          load,
    input  logic [NUM_STAGES*STAGE_W-1:0] load_val,
    output logic [NUM_STAGES*STAGE_W-1:0] data_out,
    output logic [NUM_STAGES-1:0]         stage_tc,
    output logic                          carry_out
`ifdef CNTR_SATURATE_EN
    ,
    output logic                          sat
`endif
);

    logic [NUM_STAGES:0]   chain;
    logic [NUM_STAGES-1:0] stage_adv;
    logic                  full_roll;
    logic                  carry_q;
    logic                  carry_d;

    // chain[i] is the advance condition for stage i; the top entry means every stage wraps.
    always_comb begin
        chain    = '0;
        chain[0] = en & ~load;
        for (int i = 0; i < NUM_STAGES; i++) begin
            chain[i+1] = chain[i] & stage_tc[i];
        end
    end

    assign full_roll = chain[NUM_STAGES];

`ifdef CNTR_SATURATE_EN
    logic sat_q;
    logic sat_d;

    // At a full roll-over nothing advances; any advance that does proceed is necessarily
    // in the opposite direction from the saturated end, so it clears the flag.
    assign stage_adv = chain[NUM_STAGES-1:0] & {NUM_STAGES{~full_roll}};
    assign carry_d   = 1'b0;

    always_comb begin
        sat_d = sat_q;
        if (load) begin
            sat_d = 1'b0;
        end else if (full_roll) begin
            sat_d = 1'b1;
        end else if (en) begin
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat = sat_q;
`else
    assign stage_adv = chain[NUM_STAGES-1:0];
    assign carry_d   = full_roll;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign carry_out = carry_q;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        cntr_stage #(
            .STAGE_W (STAGE_W),
            .MODULUS (MODULUS)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .adv        (stage_adv[i]),
            .sense      (sense),
            .load       (load),
            .load_digit (load_val[i*STAGE_W +: STAGE_W]),
            .digit      (data_out[i*STAGE_W +: STAGE_W]),
            .tc         (stage_tc[i])
        );
    end

endmodule

// File: tb/tb_param_cascade_cntr.sv
// Bench for param_cascade_cntr: integer-valued reference model checked every cycle, plus directed literals.
// Two instances: 2 x BCD digits and 8 x hex digits. Honours CNTR_SATURATE_EN when defined.
module tb_param_cascade_cntr;

    localparam int AN = 2;
    localparam int AM = 10;
    localparam int BN = 8;
    localparam int BM = 16;
    localparam longint A_TOT = 100;
    localparam longint B_TOT = 64'h1_0000_0000;
`ifdef CNTR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        a_en = 1'b0, a_sense = 1'b1, a_load = 1'b0;
    logic [7:0]  a_lv = '0;
    logic [7:0]  a_data;
    logic [1:0]  a_tc;
    logic        a_carry;

    logic        b_en = 1'b0, b_sense = 1'b1, b_load = 1'b0;
    logic [31:0] b_lv = '0;
    logic [31:0] b_data;
    logic [7:0]  b_tc;
    logic        b_carry;
`ifdef CNTR_SATURATE_EN
    logic        a_sat;
    logic        b_sat;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    longint ma_v = 0, mb_v = 0;
    logic   ma_c = 1'b0, mb_c = 1'b0, ma_s = 1'b0, mb_s = 1'b0;

    always #5 clk = ~clk;

    param_cascade_cntr #(.NUM_STAGES(AN), .STAGE_W(4), .MODULUS(AM)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .en        (a_en),
        .sense     (a_sense),
        .load      (a_load),
        .load_val  (a_lv),
        .data_out  (a_data),
        .stage_tc  (a_tc),
        .carry_out (a_carry)
`ifdef CNTR_SATURATE_EN
        ,
        .sat       (a_sat)
`endif
    );

    param_cascade_cntr #(.NUM_STAGES(BN), .STAGE_W(4), .MODULUS(BM)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .en        (b_en),
        .sense     (b_sense),
        .load      (b_load),
        .load_val  (b_lv),
        .data_out  (b_data),
        .stage_tc  (b_tc),
        .carry_out (b_carry)
`ifdef CNTR_SATURATE_EN
        ,
        .sat       (b_sat)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Integer count -> packed digit bus.
    function automatic logic [63:0] to_bus(input longint v, input int n, input int m);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) begin
            r[i*4 +: 4] = 4'(v % m);
            v = v / m;
        end
        return r;
    endfunction

    // Packed load bus -> integer count, clamping each digit to m-1.
    function automatic longint from_bus(input logic [63:0] bus, input int n, input int m);
        longint v = 0;
        for (int i = n - 1; i >= 0; i--) begin
            longint d = longint'(bus[i*4 +: 4]);
            if (d >= m) d = m - 1;
            v = v * m + d;
        end
        return v;
    endfunction

    function automatic logic [63:0] tc_of(input longint v, input int n, input int m, input logic sn);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) begin
            r[i] = ((v % m) == (sn ? m - 1 : 0));
            v = v / m;
        end
        return r;
    endfunction

    task automatic model_adv(input longint tot, input logic e, input logic sn, input logic ld,
                             input longint lv, inout longint v, inout logic c, inout logic s);
        c = 1'b0;
        if (ld) begin
            v = lv;
            s = 1'b0;
        end else if (e) begin
            if ((sn && v == tot - 1) || (!sn && v == 0)) begin
                if (SAT) begin
                    s = 1'b1;
                end else begin
                    v = sn ? 0 : tot - 1;
                    c = 1'b1;
                end
            end else begin
                v = sn ? v + 1 : v - 1;
                s = 1'b0;
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma_v = 0; ma_c = 1'b0; ma_s = 1'b0;
            mb_v = 0; mb_c = 1'b0; mb_s = 1'b0;
        end else begin
            model_adv(A_TOT, a_en, a_sense, a_load, from_bus(64'(a_lv), AN, AM), ma_v, ma_c, ma_s);
            model_adv(B_TOT, b_en, b_sense, b_load, from_bus(64'(b_lv), BN, BM), mb_v, mb_c, mb_s);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_data",  64'(a_data),  to_bus(ma_v, AN, AM));
            check("a_carry", 64'(a_carry), 64'(ma_c));
            check("a_tc",    64'(a_tc),    tc_of(ma_v, AN, AM, a_sense));
            check("b_data",  64'(b_data),  to_bus(mb_v, BN, BM));
            check("b_carry", 64'(b_carry), 64'(mb_c));
            check("b_tc",    64'(b_tc),    tc_of(mb_v, BN, BM, b_sense));
`ifdef CNTR_SATURATE_EN
            check("a_sat",   64'(a_sat),   64'(ma_s));
            check("b_sat",   64'(b_sat),   64'(mb_s));
`endif
        end
    end

    task automatic cyc_a(input logic e, input logic sn, input logic ld, input logic [7:0] lv);
        a_en = e; a_sense = sn; a_load = ld; a_lv = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_b(input logic e, input logic sn, input logic ld, input logic [31:0] lv);
        b_en = e; b_sense = sn; b_load = ld; b_lv = lv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_a_data",  64'(a_data),  64'h0);
        check("rst_a_carry", 64'(a_carry), 64'h0);
        check("rst_b_data",  64'(b_data),  64'h0);
        @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;

        // Up-count through the full BCD range.
        cyc_a(1'b1, 1'b1, 1'b0, 8'h00);
        check("first_count", 64'(a_data), 64'h01);
        for (int i = 0; i < 98; i++) cyc_a(1'b1, 1'b1, 1'b0, 8'h00);
        check("reach_99", 64'(a_data), 64'h99);
        check("tc_at_99", 64'(a_tc),   64'h3);
        cyc_a(1'b1, 1'b1, 1'b0, 8'h00);
`ifdef CNTR_SATURATE_EN
        check("sat_hold",  64'(a_data),  64'h99);
        check("sat_flag",  64'(a_sat),   64'h1);
        check("sat_carry", 64'(a_carry), 64'h0);
        cyc_a(1'b1, 1'b1, 1'b0, 8'h00);
        cyc_a(1'b1, 1'b1, 1'b0, 8'h00);
        check("sat_hold3", 64'(a_data), 64'h99);
        cyc_a(1'b1, 1'b0, 1'b0, 8'h00);
        check("sat_rev_data", 64'(a_data), 64'h98);
        check("sat_rev_flag", 64'(a_sat),  64'h0);
`else
        check("wrap_up_data",  64'(a_data),  64'h00);
        check("wrap_up_carry", 64'(a_carry), 64'h1);
        cyc_a(1'b0, 1'b1, 1'b0, 8'h00);
        check("idle_carry", 64'(a_carry), 64'h0);
        check("idle_hold",  64'(a_data),  64'h00);
        cyc_a(1'b1, 1'b0, 1'b0, 8'h00);
        check("wrap_dn_data",  64'(a_data),  64'h99);
        check("wrap_dn_carry", 64'(a_carry), 64'h1);
        cyc_a(1'b0, 1'b0, 1'b0, 8'h00);
        check("idle_carry2", 64'(a_carry), 64'h0);
`endif

        // Load with clamping, and load priority over enable.
        cyc_a(1'b0, 1'b1, 1'b1, 8'h5A);
        check("load_clamp_lo", 64'(a_data), 64'h59);
        cyc_a(1'b1, 1'b1, 1'b1, 8'h23);
        check("load_wins", 64'(a_data), 64'h23);
        cyc_a(1'b0, 1'b1, 1'b1, 8'hFF);
        check("load_clamp_both", 64'(a_data), 64'h99);
        cyc_a(1'b1, 1'b1, 1'b1, 8'h99);
        check("load_edge_carry", 64'(a_carry), 64'h0);
        check("load_edge_data",  64'(a_data),  64'h99);

        // Async reset mid-count.
        cyc_a(1'b0, 1'b1, 1'b1, 8'h40);
        for (int i = 0; i < 7; i++) cyc_a(1'b1, 1'b1, 1'b0, 8'h00);
        check("count_47", 64'(a_data), 64'h47);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_data",  64'(a_data),  64'h00);
        check("async_rst_carry", 64'(a_carry), 64'h0);
        a_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc_a(1'b1, 1'b1, 1'b0, 8'h00);
        check("resume_01", 64'(a_data), 64'h01);
        cyc_a(1'b0, 1'b1, 1'b0, 8'h00);

        // Eight hex stages across a multi-stage boundary, then direction reversal.
        cyc_b(1'b0, 1'b1, 1'b1, 32'h0000FFFF);
        check("b_load",    64'(b_data), 64'h0000FFFF);
        check("b_tc_ffff", 64'(b_tc),   64'h0F);
        cyc_b(1'b1, 1'b1, 1'b0, 32'h0);
        check("b_up_cross", 64'(b_data), 64'h00010000);
        cyc_b(1'b1, 1'b0, 1'b0, 32'h0);
        check("b_dn_cross", 64'(b_data), 64'h0000FFFF);
        cyc_b(1'b0, 1'b0, 1'b0, 32'h0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_cascade_cntr.md
PARAM_CASCADE_CNTR -- requirements
Module: param_cascade_cntr

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 8: number of cascaded digit stages (1..16).
REQ-002 SHALL have parameter STAGE_W, default 4: bits per stage.
REQ-003 SHALL have parameter MODULUS, default 16: per-stage count modulus (2..2**STAGE_W); 10 gives BCD.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: count enable.
REQ-007 SHALL have port sense, input, 1 bit: direction; 1 = up, 0 = down.
REQ-008 SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-009 SHALL have port load_val, input, NUM_STAGES*STAGE_W bits: load value, stage i at [i*STAGE_W +: STAGE_W].
REQ-010 SHALL have port data_out, output, NUM_STAGES*STAGE_W bits: registered count, stage packing as load_val.
REQ-011 SHALL have port stage_tc, output, NUM_STAGES bits: combinational per-stage terminal flag (MODULUS-1 when sense=1, 0 when sense=0).
REQ-012 SHALL have port carry_out, output, 1 bit: registered one-cycle wrap pulse.
REQ-013 SHALL have port sat, output, 1 bit: saturation status; present only when CNTR_SATURATE_EN is defined.

Function
REQ-014 Stage 0 SHALL advance on every clk edge with en=1, load=0.
REQ-015 Stage i>0 SHALL advance only when en=1, load=0 and stage_tc[i-1:0] are all 1.
REQ-016 Advance up SHALL go MODULUS-1 -> 0; advance down SHALL go 0 -> MODULUS-1; every other advance is +/-1.
REQ-017 A sense change SHALL take effect on the same edge, with no idle cycle.
REQ-018 load=1 SHALL take priority over en; load SHALL write all stages on that edge.
REQ-019 A loaded stage field >= MODULUS SHALL be clamped to MODULUS-1.
REQ-020 en=0 with load=0 SHALL hold all stages; carry_out SHALL be 0.
REQ-021 carry_out SHALL be 1 for exactly the cycle after an edge on which every stage wrapped (full-count roll-over in either direction).
REQ-022 carry_out SHALL be 0 on a load edge.
REQ-023 The counter SHALL have 1-cycle latency from enable to data_out.
REQ-024 The counter SHALL have no state machine beyond the stage registers, the carry_out register and the sat flag.

Reset
REQ-025 rst=0 SHALL asynchronously force data_out=0, carry_out=0 and sat=0, regardless of clk.
REQ-026 Reset deassertion SHALL be synchronised externally; the first count occurs on the first edge with rst=1 and en=1.
REQ-027 Reset asserted mid-count SHALL discard the count with no residual carry pulse.

Configuration
REQ-028 With macro CNTR_SATURATE_EN defined, a full roll-over SHALL be suppressed: the count holds at all-(MODULUS-1) going up or all-0 going down, sat goes to 1 and carry_out stays 0.
REQ-029 With CNTR_SATURATE_EN defined, sat SHALL clear on load, on rst, or on an advance in the opposite direction; that advance proceeds normally.
REQ-030 Without CNTR_SATURATE_EN, the sat port and its logic SHALL be absent and the counter SHALL wrap per REQ-021.

Structure
REQ-031 Package cntr_pkg SHALL hold the default parameter constants and the direction constants DIR_UP=1 and DIR_DN=0.
REQ-032 Sub-module cntr_stage SHALL implement one digit (inputs: advance, sense, load, load digit; outputs: digit, tc) and be instantiated NUM_STAGES times in a generate loop.
REQ-033 The cascade enable chain and carry_out/sat logic SHALL reside in the top module.

Verification (NUM_STAGES=2, STAGE_W=4, MODULUS=10 unless stated)
REQ-034 rst low, then en=1, sense=1 for 100 cycles -> data_out steps 0x00..0x99, then 0x00; carry_out high exactly one cycle after the 0x99->0x00 edge.
REQ-035 From 0x00, sense=0, en=1 for one cycle -> data_out=0x99, carry_out pulses once.
REQ-036 load=1, load_val=0x5A -> data_out=0x59; load and en high together -> load wins.
REQ-037 Counting at 0x47, assert rst asynchronously mid-cycle -> data_out=0x00 immediately, carry_out=0; count resumes from 0x01 after release.
REQ-038 CNTR_SATURATE_EN defined, up-count to 0x99 then 3 more enables -> data_out holds 0x99, sat=1, carry_out=0; then sense=0 -> 0x98, sat=0.
REQ-039 NUM_STAGES=8, MODULUS=16, sense toggled at 0x0000FFFF -> 0x00010000 going up, then back to 0x0000FFFF going down.
